// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, memory-stage FSM states and bus command payload.
package y86_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned ICODE_W = 4;

  localparam logic [ICODE_W-1:0] I_RMMOVQ = 4'h4;
  localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
  localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
  localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
  localparam logic [ICODE_W-1:0] I_PUSHQ  = 4'hA;
  localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/dmem_op_decode.sv
// Maps a memory-stage instruction onto a single read or write: direction, address and write data.
module dmem_op_decode
  import y86_pkg::*;
(
  input  logic [ICODE_W-1:0] icode,
  input  logic [XLEN-1:0]    valA,
  input  logic [XLEN-1:0]    valE,
  input  logic [XLEN-1:0]    valP,
  output logic               is_rd,
  output logic               is_wr,
  output logic [XLEN-1:0]    addr,
  output logic [XLEN-1:0]    wdata
);

  always_comb begin
    is_rd = 1'b0;
    is_wr = 1'b0;
    addr  = valE;
    wdata = valA;
    case (icode)
      I_RMMOVQ, I_PUSHQ: is_wr = 1'b1;
      I_CALL: begin
        is_wr = 1'b1;
        wdata = valP;
      end
      I_MRMOVQ: is_rd = 1'b1;
      // Stack pops address through the old stack pointer in valA
      I_RET, I_POPQ: begin
        is_rd = 1'b1;
        addr  = valA;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_requester.sv
// Memory-stage initiator: one req/gnt/rvalid transaction per instruction, with address
// range checking, a REQ+WAIT timeout and a held read-data register.
module dmem_requester
  import y86_pkg::*;
#(
  parameter int unsigned ADDR_MAX = 8192,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned CNT_W    = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m_valid,
  input  logic [ICODE_W-1:0] icode,
  input  logic [XLEN-1:0]    valA,
  input  logic [XLEN-1:0]    valE,
  input  logic [XLEN-1:0]    valP,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    valM,
  output logic               dmem_error,
  output logic               mem_req,
  output logic               mem_we,
  output logic [XLEN-1:0]    mem_addr,
  output logic [XLEN-1:0]    mem_wdata,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata
);

  state_t          state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic            err, err_n;
  mem_cmd_t        cmd, cmd_n;
  logic [XLEN-1:0] valm_n;
  logic            timed_out;

  logic            dec_rd, dec_wr;
  logic [XLEN-1:0] dec_addr, dec_wdata;

  dmem_op_decode u_decode (
    .icode (icode),
    .valA  (valA),
    .valE  (valE),
    .valP  (valP),
    .is_rd (dec_rd),
    .is_wr (dec_wr),
    .addr  (dec_addr),
    .wdata (dec_wdata)
  );

  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

  // Last permitted REQ/WAIT cycle: the counter reaches TIMEOUT on the edge that leaves it
  assign timed_out = (cnt >= CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      err        <= 1'b0;
      cmd        <= '0;
      valM       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dmem_error <= 1'b0;
      mem_req    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      err        <= err_n;
      cmd        <= cmd_n;
      valM       <= valm_n;
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
      dmem_error <= (state_n == DONE) && err_n;
      mem_req    <= (state_n == REQ);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = err;
    cmd_n   = cmd;
    valm_n  = valM;
    case (state)
      IDLE: begin
        cnt_n = '0;
        err_n = 1'b0;
        if (m_valid) begin
          cmd_n.we    = dec_wr;
          cmd_n.addr  = dec_addr;
          cmd_n.wdata = dec_wdata;
          if (!(dec_rd || dec_wr)) begin
            state_n = DONE;
          end else if (dec_addr > XLEN'(ADDR_MAX)) begin
            state_n = DONE;
            err_n   = 1'b1;
          end else begin
            state_n = REQ;
          end
        end
      end
      REQ: begin
        cnt_n = cnt + CNT_W'(1);
        // A completion in the final allowed cycle wins over the timeout
        if (mem_gnt && cmd.we) begin
          state_n = DONE;
        end else if (mem_gnt && mem_rvalid) begin
          valm_n  = mem_rdata;
          state_n = DONE;
        end else if (timed_out) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else if (mem_gnt) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt + CNT_W'(1);
        if (mem_rvalid) begin
          valm_n  = mem_rdata;
          state_n = DONE;
        end else if (timed_out) begin
          state_n = DONE;
          err_n   = 1'b1;
        end
      end
      DONE: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
